// File: rtl/ray_aabb_sched_if.sv
// Signal bundle for ray_aabb_sched: two job requesters, the shared
// intersection datapath, and the two per-requester result streams.
`timescale 1ns/1ps
interface ray_aabb_sched_if #(
  parameter int W = 447
);
  logic         req0_valid;
  logic         req0_ready;
  logic [W-1:0] req0_data;
  logic         req1_valid;
  logic         req1_ready;
  logic [W-1:0] req1_data;
  logic         dp_valid;
  logic [W-1:0] dp_data;
  logic         dp_hit;
  logic         res0_valid;
  logic         res0_hit;
  logic         res0_ready;
  logic         res1_valid;
  logic         res1_hit;
  logic         res1_ready;
  logic         busy;

  // master: the scheduler itself; slave: requesters plus datapath around it.
  modport master (
    input  req0_valid, req0_data, req1_valid, req1_data, dp_hit, res0_ready, res1_ready,
    output req0_ready, req1_ready, dp_valid, dp_data, res0_valid, res0_hit,
           res1_valid, res1_hit, busy
  );

  modport slave (
    output req0_valid, req0_data, req1_valid, req1_data, dp_hit, res0_ready, res1_ready,
    input  req0_ready, req1_ready, dp_valid, dp_data, res0_valid, res0_hit,
           res1_valid, res1_hit, busy
  );
endinterface

// File: rtl/ray_aabb_sched.sv
// Round-robin, credit-based sharing of one fixed-latency ray/AABB unit between
// two requesters; returned hit bits are steered by tag into per-requester FIFOs.
`timescale 1ns/1ps
module ray_aabb_sched #(
  parameter int LAT   = 12,
  parameter int DEPTH = 4,
  parameter int W     = 447
) (
  input  logic             clk,
  input  logic             rst,
  ray_aabb_sched_if.master bus
);
  localparam int              AW      = $clog2(DEPTH);
  localparam int              CW      = AW + 1;
  localparam logic [CW:0]     DEPTH_C = (CW+1)'(DEPTH);

  typedef struct packed {
    logic valid;
    logic id;
  } tag_t;

  logic [1:0]       req_valid, res_ready, res_valid;
  logic [1:0]       elig, grant, push, pop;
  logic [W-1:0]     req_data [2];

  logic             last_q;
  logic             dp_valid_q;
  logic             dp_id_q;
  logic [W-1:0]     dp_data_q;
  tag_t             tag_q [LAT];
  tag_t             ret;

  logic [CW-1:0]    occ_q  [2];
  logic [CW-1:0]    infl_q [2];
  logic [AW-1:0]    wr_q   [2];
  logic [AW-1:0]    rd_q   [2];
  logic [DEPTH-1:0] mem_q  [2];

  assign req_valid   = {bus.req1_valid, bus.req0_valid};
  assign res_ready   = {bus.res1_ready, bus.res0_ready};
  assign req_data[0] = bus.req0_data;
  assign req_data[1] = bus.req1_data;

  // Credit = FIFO slots not yet promised: occupancy plus jobs still in flight.
  always_comb begin
    // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latch).
    elig  = '0;
    grant = '0;
    for (int i = 0; i < 2; i++)
      elig[i] = req_valid[i] && (({1'b0, occ_q[i]} + {1'b0, infl_q[i]}) < DEPTH_C);
    grant = elig;
    if (&elig) grant = last_q ? 2'b01 : 2'b10;
  end

  assign ret = tag_q[LAT-1];
  assign push = {ret.valid & ret.id, ret.valid & ~ret.id};

  for (genvar i = 0; i < 2; i++) begin : g_res
    assign res_valid[i] = (occ_q[i] != '0);
    assign pop[i]       = res_valid[i] & res_ready[i];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_q     <= 1'b1;
      dp_valid_q <= 1'b0;
      dp_id_q    <= 1'b0;
      dp_data_q  <= '0;
      for (int j = 0; j < LAT; j++) tag_q[j] <= '0;
      for (int i = 0; i < 2; i++) begin
        occ_q[i]  <= '0;
        infl_q[i] <= '0;
        wr_q[i]   <= '0;
        rd_q[i]   <= '0;
      end
    end else begin
      // NOTE: all state updates are non-blocking so every RHS sees pre-edge values.
      dp_valid_q <= |grant;
      if (|grant) begin
        dp_id_q   <= grant[1];
        dp_data_q <= grant[1] ? req_data[1] : req_data[0];
        last_q    <= grant[1];
      end
      // The tag trails dp_valid so it exits exactly when the unit's answer is due.
      tag_q[0] <= tag_t'{valid: dp_valid_q, id: dp_id_q};
      for (int j = 1; j < LAT; j++) tag_q[j] <= tag_q[j-1];
      for (int i = 0; i < 2; i++) begin
        infl_q[i] <= infl_q[i] + CW'(grant[i]) - CW'(push[i]);
        occ_q[i]  <= occ_q[i] + CW'(push[i]) - CW'(pop[i]);
        if (push[i]) wr_q[i] <= wr_q[i] + AW'(1);
        if (pop[i])  rd_q[i] <= rd_q[i] + AW'(1);
      end
    end
  end

  // NOTE: result storage has no reset; occupancy and pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++)
      if (push[i]) mem_q[i][wr_q[i]] <= bus.dp_hit;
  end

  assign bus.req0_ready = grant[0];
  assign bus.req1_ready = grant[1];
  assign bus.dp_valid   = dp_valid_q;
  assign bus.dp_data    = dp_data_q;
  assign bus.res0_valid = res_valid[0];
  assign bus.res1_valid = res_valid[1];
  // Gate with valid so a stale storage bit never shows after reset.
  assign bus.res0_hit   = res_valid[0] & mem_q[0][rd_q[0]];
  assign bus.res1_hit   = res_valid[1] & mem_q[1][rd_q[1]];
  assign bus.busy       = (|infl_q[0]) | (|infl_q[1]) | (|res_valid);
endmodule

// File: tb/tb_ray_aabb_sched.sv
// Self-checking bench for ray_aabb_sched: behavioural LAT-cycle datapath stand-in,
// per-requester scoreboards, directed vector table and random traffic.
`timescale 1ns/1ps
module tb_ray_aabb_sched;
  localparam int LAT   = 12;
  localparam int DEPTH = 4;
  localparam int W     = 447;

  typedef struct {
    logic [W-1:0] job;
    logic         exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ray_aabb_sched_if #(.W(W)) bus ();

  ray_aabb_sched #(.LAT(LAT), .DEPTH(DEPTH), .W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int ovf_cnt  = 0;
  logic exp_q0 [$];
  logic exp_q1 [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Stand-in intersection unit: hit = parity(x0) ^ sign x.
  function automatic logic unit_hit(input logic [W-1:0] j);
    return (^j[446:410]) ^ j[2];
  endfunction

  function automatic logic [W-1:0] make_job(input logic [36:0] x0, input logic [36:0] divx,
                                            input logic sx, input logic sy, input logic sz);
    logic [W-1:0] j;
    j          = '0;
    j[446:410] = x0;
    j[113:77]  = divx;
    j[2]       = sx;
    j[1]       = sy;
    j[0]       = sz;
    return j;
  endfunction

  function automatic logic [W-1:0] rand_job();
    logic [W-1:0] j;
    for (int k = 0; k < W; k++) j[k] = 1'($urandom_range(0, 1));
    return j;
  endfunction

  function automatic logic [7:0] outs();
    return {bus.req0_ready, bus.req1_ready, bus.dp_valid, bus.res0_valid,
            bus.res0_hit, bus.res1_valid, bus.res1_hit, bus.busy};
  endfunction

  // Datapath model: answer appears LAT cycles after dp_valid; junk otherwise.
  logic [LAT-1:0] hit_pipe;
  always @(posedge clk)
    hit_pipe <= {hit_pipe[LAT-2:0], bus.dp_valid ? unit_hit(bus.dp_data) : 1'($urandom_range(0, 1))};
  assign bus.dp_hit = hit_pipe[LAT-1];

  // Scoreboard: push on accept, pop/compare on result handshake.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      exp_q0.delete();
      exp_q1.delete();
    end else begin
      if (bus.res0_valid && bus.res0_ready) begin
        if (exp_q0.size() == 0) check("sb0_unexpected", 1, 0);
        else check("sb0_hit", bus.res0_hit, exp_q0.pop_front());
      end
      if (bus.res1_valid && bus.res1_ready) begin
        if (exp_q1.size() == 0) check("sb1_unexpected", 1, 0);
        else check("sb1_hit", bus.res1_hit, exp_q1.pop_front());
      end
      if (bus.req0_valid && bus.req0_ready) exp_q0.push_back(unit_hit(bus.req0_data));
      if (bus.req1_valid && bus.req1_ready) exp_q1.push_back(unit_hit(bus.req1_data));
      if (exp_q0.size() > DEPTH || exp_q1.size() > DEPTH) ovf_cnt++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    int guard = 0;
    @(negedge clk);
    while (bus.busy && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    check(name, bus.busy, 0);
    tick();
  endtask

  initial begin
    vec_t vec [5];
    logic [W-1:0] hit1, miss1;
    int n, acc0, acc1, late0, acc, viol, got, guard2;

    hit1  = make_job(37'b0100111111111001101011011111110001101,
                     37'b0110111111111110000110010101111110000, 1'b0, 1'b0, 1'b0);
    miss1 = make_job(37'b0100111111111001101011011111110001101,
                     37'b0110111111111110000110010101111110000, 1'b1, 1'b0, 1'b0);
    vec[0] = '{job: hit1,                                  exp: 1'b1};
    vec[1] = '{job: miss1,                                 exp: 1'b0};
    vec[2] = '{job: make_job(37'h3, 37'h1234, 1'b1, 1'b0, 1'b1), exp: 1'b1};
    vec[3] = '{job: make_job(37'h1, 37'h0, 1'b0, 1'b1, 1'b1),    exp: 1'b1};
    vec[4] = '{job: make_job(37'h0, 37'h55, 1'b0, 1'b1, 1'b0),   exp: 1'b0};

    bus.req0_valid = 0; bus.req0_data = '0; bus.res0_ready = 0;
    bus.req1_valid = 0; bus.req1_data = '0; bus.res1_ready = 0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outs", outs(), 8'h00);
    check("reset_dp_data_zero", bus.dp_data == '0, 1);
    tick();
    rst = 1'b1;
    tick();

    // Single hit job: dp_valid pulse and LAT+1 return latency
    bus.req0_data = hit1; bus.req0_valid = 1;
    @(negedge clk);
    check("first_ready_req0", {bus.req1_ready, bus.req0_ready}, 2'b01);
    tick();
    bus.req0_valid = 0;
    @(negedge clk);
    check("dp_valid_after_accept", bus.dp_valid, 1);
    check("dp_data_after_accept", bus.dp_data == hit1, 1);
    tick(); n = 1;
    @(negedge clk);
    check("dp_valid_one_pulse", bus.dp_valid, 0);
    while (!bus.res0_valid && n < 4*LAT) begin
      tick(); n++;
      @(negedge clk);
    end
    check("res0_latency", n, LAT+1);
    check("res0_hit_first", bus.res0_hit, 1);

    // Three more in flight, then a 1-cycle reset with res0_valid still high
    tick();
    bus.req0_valid = 1;
    repeat (3) tick();
    bus.req0_valid = 0;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("midflight_reset_outs", outs(), 8'h00);
    check("midflight_reset_dp_data", bus.dp_data == '0, 1);
    tick();
    rst = 1'b1;
    viol = 0;
    for (int c = 0; c < 2*LAT+4; c++) begin
      @(negedge clk);
      if (bus.res0_valid || bus.res1_valid || bus.busy || bus.dp_valid) viol++;
      tick();
    end
    check("no_stale_after_reset", viol, 0);

    // Arbitration: alternate starting with req0; routing checked by scoreboard
    bus.res0_ready = 1; bus.res1_ready = 1;
    bus.req0_data = hit1; bus.req1_data = miss1;
    bus.req0_valid = 1; bus.req1_valid = 1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check($sformatf("arb_grant%0d", c), {bus.req1_ready, bus.req0_ready},
            (c % 2 == 0) ? 2'b01 : 2'b10);
      tick();
    end
    bus.req0_valid = 0; bus.req1_valid = 0;
    drain("arb_drain");

    // Backpressure on requester 1 only
    bus.res0_ready = 1; bus.res1_ready = 0;
    bus.req0_data = vec[2].job; bus.req1_data = vec[0].job;
    bus.req0_valid = 1; bus.req1_valid = 1;
    acc0 = 0; acc1 = 0; late0 = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.req0_ready) begin acc0++; if (c >= 20) late0++; end
      if (bus.req1_ready) acc1++;
      tick();
    end
    check("bp_req1_accepts", acc1, DEPTH);
    check("bp_req0_continues", late0 != 0, 1);
    bus.req0_valid = 0;
    repeat (LAT+4) @(posedge clk);
    #1;
    bus.res1_ready = 1;
    @(negedge clk);
    check("bp_pop_pending", {bus.res1_valid, bus.req1_ready}, 2'b10);
    tick();
    @(negedge clk);
    check("bp_req1_resumes", bus.req1_ready, 1);
    tick();
    bus.req1_valid = 0;
    drain("bp_drain");

    // Random traffic: simultaneous grant/return/pop, scoreboard-checked
    acc = 0;
    for (int c = 0; c < 20000 && acc < 1000; c++) begin
      bus.req0_valid = ($urandom_range(0, 9) < 7);
      bus.req1_valid = ($urandom_range(0, 9) < 7);
      bus.req0_data  = rand_job();
      bus.req1_data  = rand_job();
      bus.res0_ready = ($urandom_range(0, 9) < 6);
      bus.res1_ready = ($urandom_range(0, 9) < 6);
      @(negedge clk);
      acc += int'(bus.req0_valid && bus.req0_ready) + int'(bus.req1_valid && bus.req1_ready);
      tick();
    end
    bus.req0_valid = 0; bus.req1_valid = 0;
    bus.res0_ready = 1; bus.res1_ready = 1;
    check("rand_job_count", acc >= 1000, 1);
    drain("rand_drain");
    check("rand_sb_empty", exp_q0.size() + exp_q1.size(), 0);
    check("credit_never_exceeded", ovf_cnt, 0);

    // Ordering: five back-to-back req0 jobs from the vector table
    bus.res0_ready = 1;
    fork
      begin
        for (int i = 0; i < 5; i++) begin
          logic acc_d;
          int   guard;
          bus.req0_data = vec[i].job; bus.req0_valid = 1;
          acc_d = 0; guard = 0;
          while (!acc_d && guard < 100) begin
            @(negedge clk);
            acc_d = bus.req0_ready;
            guard++;
            tick();
          end
          bus.req0_valid = 0;
        end
      end
      begin
        got = 0; guard2 = 0;
        while (got < 5 && guard2 < 400) begin
          @(negedge clk);
          guard2++;
          if (bus.res0_valid) begin
            check($sformatf("ord_hit%0d", got), bus.res0_hit, vec[got].exp);
            got++;
          end
        end
        check("ord_count", got, 5);
        @(negedge clk);
        check("ord_busy_drop", bus.busy, 0);
      end
    join
    check("final_sb_empty", exp_q0.size() + exp_q1.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/ray_aabb_sched.md
Name: ray_aabb_sched

Overview:
- Round-robin scheduler that shares one fully pipelined Ray_AABB_11_23 intersection unit between two requesters, e.g. two traversal engines.
- Each job is one ray/box test: 9 box-corner operands, 3 reciprocal-direction operands (37-bit FloPoCo floats), and 3 sign bits.
- The block arbitrates jobs into the datapath and tags each in-flight job with its requester.
- It steers each returned hit_miss into a per-requester result FIFO. Credit-based issue guarantees that no result is ever dropped, because the datapath cannot stall.

Parameters:
- LAT, 12, fixed datapath latency in cycles from dp_valid/dp_data to the matching dp_hit; must be ≥1.
- DEPTH, 4, entries per result FIFO; power of 2, ≥2.
- W, 447, job width; 12×37+3, fixed.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- req0_valid  in  1  requester 0 offers a job.
- req0_ready  out  1  requester 0 job accepted this cycle.
- req0_data  in  W  job. Field order: x0[446:410], y0, z0, x1, y1, z1, x2, y2, z2, divx, divy, divz[39:3], x[2], y[1], z[0].
- req1_valid  in  1  as req0_valid, for requester 1.
- req1_ready  out  1  as req0_ready, for requester 1.
- req1_data  in  W  as req0_data, for requester 1.
- dp_valid  out  1  job presented to the datapath, registered.
- dp_data  out  W  registered job; fields as req0_data, wired to the unit's operand ports.
- dp_hit  in  1  unit hit_miss output.
- res0_valid  out  1  requester 0 result FIFO non-empty.
- res0_hit  out  1  head result for requester 0.
- res0_ready  in  1  pop for requester 0.
- res1_valid  out  1  as res0_valid, for requester 1.
- res1_hit  out  1  as res0_hit, for requester 1.
- res1_ready  in  1  as res0_ready, for requester 1.
- busy  out  1  any job in flight or any result FIFO non-empty.

Behaviour:
- Reset (rst=0, async): clears dp_valid, dp_data, tag pipeline, both FIFOs, in-flight counters and the RR pointer (last=1, so req0 wins first). All outputs read 0.
- Reset mid-operation discards in-flight jobs. dp_hit returning after reset deassertion is ignored.
- Eligibility, for each i: elig_i = reqi_valid & (occ_i + infl_i < DEPTH).
  - occ_i is FIFO occupancy; infl_i is the count of tags for i in the pipeline. Both counters are clog2(DEPTH)+1 bits.
- Grant: at most one per cycle.
  - If only one requester is eligible, it is granted.
  - If both are eligible, the one ≠ last is granted.
  - last updates on grant only.
- reqi_ready = grant_i, combinational from valid, credit and pointer; it does not depend on ready.
- Accept at edge k (valid & ready):
  - dp_data <= reqi_data and dp_valid <= 1, visible in cycle k+1.
  - A tag {valid=1, id=i} enters the LAT-deep shift register.
  - With no grant, dp_valid <= 0 and dp_data holds its last value.
- Return: dp_hit is sampled when the tag exits, LAT cycles after dp_valid is visible.
  - At that edge, dp_hit is pushed into FIFO[id] and infl_id is decremented.
  - The result is visible on resi_valid/resi_hit the following cycle.
- FIFO:
  - Pop on resi_valid & resi_ready.
  - Push and pop in the same cycle are both allowed; occupancy is unchanged.
  - Pop from an empty FIFO is ignored.
  - Overflow cannot occur by construction; the bench asserts this.
- Credit counts in-flight jobs, so a full FIFO with res_ready=0 throttles only its own requester; the other requester continues at full rate.
- Throughput: 1 job/cycle sustained. Results per requester are returned in issue order.
- Simultaneous events in one cycle (grant to i, return to i, pop from i): infl_i = infl_i + 1 − 1, occ_i = occ_i + 1 − 1. Both are unchanged, and credit is computed from pre-edge values.
- busy = |infl0 | |infl1 | res0_valid | res1_valid.

Test Plan:
- Reset mid-flight:
  - Stimulus: after reset release, req0 issues hit1 job. Fields: x0=0100111111111001101011011111110001101 …, x=y=z=0, divx=0110111111111110000110010101111110000.
  - Required: dp_valid pulses 1 cycle, 1 cycle after accept; res0_valid=1, res0_hit=1 at accept+LAT+1.
  - Then rst=0 for 1 cycle, applied while res0_valid is still high and 3 further jobs are in flight. Required: all outputs 0, and no stale result afterwards.
- Arbitration: both requesters valid every cycle, res ready=1 → grants alternate 0,1,0,1 starting with req0. Results: hit1 job→1; same job with x=1→0 (miss), routed by tag.
- Backpressure: res1_ready=0, req1 always valid → req1_ready goes low after DEPTH=4 accepts. req0 continues 1/cycle. Raising res1_ready restores req1 issue 1 cycle after the first pop.
- Simultaneous events: grant, return and pop on the same requester in one cycle → occ/infl unchanged, no lost or duplicated result; 1000 random jobs checked against a scoreboard.
- Ordering: 5 back-to-back req0 jobs with hit1, miss, hit2, hit3, miss → res0_hit sequence 1,0,1,1,0. busy drops 1 cycle after the last pop.
